// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-PC select encodings, the nop word,
// the fetch FSM state type and the IF/ID payload.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } ifid_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register holding {valid, instr, pcplus4}.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en_i       : load d_i
//   clr_i      : load a bubble (takes priority over en_i)
//   d_i        : incoming payload
//   q_o        : registered payload
module ifid_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en_i,
  input  logic  clr_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  localparam ifid_t BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pcplus4: '0};

  ifid_t q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= BUBBLE;
    end else if (clr_i) begin
      q_q <= BUBBLE;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time requests to a
// variable-latency instruction memory and fills IF/ID with instructions or
// bubbles, honouring decode-stage redirects.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   stallF, stallD        : hazard-unit stalls for fetch issue / IF/ID
//   pcsrcD, orpcsrcD      : next-PC select and redirect request from decode
//   pcbranchD             : branch target from decode
//   imem_req, imem_addr   : request pulse and address (= pcF)
//   imem_valid, imem_rdata: response strobe and instruction word
//   pcF                   : current fetch PC
//   instrD, pcplus4D      : IF/ID contents
//   validD                : IF/ID holds a real instruction
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic [1:0]  pcsrcD,
  input  logic        orpcsrcD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  fetch_state_t state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_inc;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] hbuf_instr_q, hbuf_instr_d;
  logic [XLEN-1:0] hbuf_pc_q, hbuf_pc_d;    // PC+4 of the buffered word

  logic            redirect;
  logic            is_jump;
  logic [XLEN-1:0] target;
  logic            outstanding;

  ifid_t ifid_q, ifid_d;
  logic  ifid_en, ifid_clr;

  // Redirect is only taken for a real instruction that is leaving IF/ID.
  assign redirect    = orpcsrcD & ifid_q.valid & ~stallD;
  // 10 and 11 both select the jump target.
  assign is_jump     = (pcsrcD != PCSRC_PLUS4) && (pcsrcD != PCSRC_BRANCH);
  assign target      = is_jump ? {ifid_q.pcplus4[31:28], ifid_q.instr[25:0], 2'b00}
                               : pcbranchD;
  assign pc_inc      = pc_plus4(pc_q);
  // A request is in flight and its response has not arrived yet.
  assign outstanding = (state_q == ST_WAIT) && !imem_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, drop flag and hold buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      hbuf_instr_q <= '0;
      hbuf_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      hbuf_instr_q <= hbuf_instr_d;
      hbuf_pc_q    <= hbuf_pc_d;
    end
  end

  // Next-state logic; a redirect overrides the normal flow.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = outstanding ? ST_WAIT : ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: if (!stallF) state_d = ST_WAIT;
        ST_WAIT:  if (imem_valid) state_d = (drop_q || !stallD) ? ST_FETCH : ST_HOLD;
        ST_HOLD:  if (!stallD) state_d = ST_FETCH;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  // Request, PC update, hold buffer and IF/ID control.
  always_comb begin
    imem_req     = 1'b0;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hbuf_instr_d = hbuf_instr_q;
    hbuf_pc_d    = hbuf_pc_q;
    ifid_en      = 1'b0;
    ifid_d       = '{valid: 1'b1, instr: imem_rdata, pcplus4: pc_inc};

    if (redirect) begin
      pc_d   = target;
      // A stale response still has to come back and be discarded.
      drop_d = outstanding;
    end else begin
      case (state_q)
        ST_FETCH: imem_req = ~stallF & ~reset;
        ST_WAIT: begin
          if (imem_valid) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              pc_d = pc_inc;
              if (!stallD) begin
                ifid_en = 1'b1;
              end else begin
                hbuf_instr_d = imem_rdata;
                hbuf_pc_d    = pc_inc;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!stallD) begin
            ifid_en = 1'b1;
            ifid_d  = '{valid: 1'b1, instr: hbuf_instr_q, pcplus4: hbuf_pc_q};
          end
        end
        default: ;
      endcase
    end

    // Any unstalled cycle without a delivery inserts a bubble.
    ifid_clr = ~stallD & ~ifid_en;
  end

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (ifid_en),
    .clr_i (ifid_clr),
    .d_i   (ifid_d),
    .q_o   (ifid_q)
  );

  assign imem_addr = pc_q;
  assign pcF       = pc_q;
  assign instrD    = ifid_q.instr;
  assign pcplus4D  = ifid_q.pcplus4;
  assign validD    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC   = 32'h0040_0000;
  localparam int          N_CYC    = 3000;
  localparam int          PH1_CYC  = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD;
  logic [1:0]  pcsrcD;
  logic        orpcsrcD;
  logic [31:0] pcbranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] pcF, instrD, pcplus4D;
  logic        validD;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .stallF     (stallF),
    .stallD     (stallD),
    .pcsrcD     (pcsrcD),
    .orpcsrcD   (orpcsrcD),
    .pcbranchD  (pcbranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .pcF        (pcF),
    .instrD     (instrD),
    .pcplus4D   (pcplus4D),
    .validD     (validD)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_deliv = 0;
  bit phase1 = 1'b1;

  // Program-order addresses expected to appear in IF/ID next.
  logic [31:0] exp_q[$];

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Monitor: checks IF/ID after every rising edge.
  logic [31:0] m_ea, m_cur_i, m_cur_p;
  bit          m_cur_v = 1'b0;
  int          m_cyc = 0;
  int          m_last = -1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_cyc++;
      if (reset) begin
        n_chk++;
        if (validD !== 1'b0 || instrD !== NOP_INSTR || pcplus4D !== 32'h0 ||
            pcF !== RST_PC || imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_state: validD=%0b instrD=%h pcplus4D=%h pcF=%h imem_req=%0b, required 0 %h 0 %h 0",
                   validD, instrD, pcplus4D, pcF, imem_req, NOP_INSTR, RST_PC);
        end
        m_cur_v = 1'b0;
        m_last  = -1;
      end else if (!stallD) begin
        if (validD === 1'b1) begin
          n_chk++;
          n_deliv++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL deliver: unexpected instrD=%h pcplus4D=%h, required no delivery", instrD, pcplus4D);
          end else begin
            m_ea    = exp_q.pop_front();
            m_cur_i = mem_word(m_ea);
            m_cur_p = m_ea + 32'd4;
            if (instrD !== m_cur_i || pcplus4D !== m_cur_p) begin
              n_fail++;
              $display("FAIL deliver: instrD=%h pcplus4D=%h, required %h %h",
                       instrD, pcplus4D, m_cur_i, m_cur_p);
            end
          end
          m_cur_v = 1'b1;
          if (phase1 && m_last >= 0) begin
            n_chk++;
            if (m_cyc - m_last != 2) begin
              n_fail++;
              $display("FAIL throughput_gap: %0d cycles, required 2", m_cyc - m_last);
            end
          end
          m_last = m_cyc;
        end else begin
          n_chk++;
          if (validD !== 1'b0 || instrD !== NOP_INSTR || pcplus4D !== 32'h0) begin
            n_fail++;
            $display("FAIL bubble: validD=%b instrD=%h pcplus4D=%h, required 0 %h 0",
                     validD, instrD, pcplus4D, NOP_INSTR);
          end
          m_cur_v = 1'b0;
        end
      end else begin
        n_chk++;
        if (validD !== m_cur_v || (m_cur_v && (instrD !== m_cur_i || pcplus4D !== m_cur_p))) begin
          n_fail++;
          $display("FAIL stallD_hold: validD=%b instrD=%h pcplus4D=%h, required %b %h %h",
                   validD, instrD, pcplus4D, m_cur_v, m_cur_i, m_cur_p);
        end
      end
    end
  end

  // Stimulus, memory model and reference model of the program-order stream.
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr;
  logic [31:0] nxt, tgt, a4, w;
  bit          chk_tgt = 1'b0;
  bit          first_req = 1'b0;
  bit          did_rst = 1'b0;
  bit          redir;
  int          rst_left = 3;

  initial begin
    reset = 1'b1; stallF = 1'b0; stallD = 1'b0; pcsrcD = PCSRC_PLUS4;
    orpcsrcD = 1'b0; pcbranchD = 32'h0; imem_valid = 1'b0; imem_rdata = 32'h0;
    nxt = RST_PC; tgt = 32'h0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #2;
      if (chk_tgt) begin
        n_chk++;
        if (pcF !== tgt) begin
          n_fail++;
          $display("FAIL redirect_pc: pcF=%h, required %h", pcF, tgt);
        end
        chk_tgt = 1'b0;
      end
      imem_valid = 1'b0;
      imem_rdata = $urandom();

      // Mid-run reset while a request is still in flight.
      if (!did_rst && !reset && cyc > N_CYC / 2 && pend && cnt > 1) begin
        did_rst  = 1'b1;
        rst_left = 2;
      end

      if (rst_left > 0) begin
        rst_left--;
        reset    = 1'b1;
        pend     = 1'b0;
        chk_tgt  = 1'b0;
        stallF   = 1'b0;
        stallD   = 1'b0;
        orpcsrcD = 1'b0;
        pcsrcD   = PCSRC_PLUS4;
      end else begin
        if (reset) begin
          reset = 1'b0;
          exp_q.delete();
          nxt = RST_PC;
          exp_q.push_back(nxt);
          first_req = 1'b1;
        end

        if (pend) begin
          if (cnt <= 1) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(paddr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end

        phase1    = (cyc < PH1_CYC);
        orpcsrcD  = 1'b0;
        pcsrcD    = PCSRC_PLUS4;
        pcbranchD = $urandom() & 32'hFFFF_FFFC;
        if (phase1) begin
          stallD = 1'b0;
          stallF = 1'b0;
        end else begin
          stallD = ($urandom_range(0, 99) < 20);
          stallF = ($urandom_range(0, 99) < 15);
          if (validD && !stallD) begin
            if ($urandom_range(0, 99) < 25) begin
              pcsrcD   = 2'($urandom_range(1, 3));
              orpcsrcD = 1'b1;
            end
          end else if ($urandom_range(0, 99) < 30) begin
            // Request that must be ignored (bubble or stalled decode).
            pcsrcD   = 2'($urandom_range(1, 3));
            orpcsrcD = 1'b1;
          end
        end
        if (first_req) stallF = 1'b0;

        // The IF/ID entry leaves decode this cycle: predict its successor.
        redir = validD && !stallD && orpcsrcD;
        if (validD && !stallD) begin
          a4 = nxt + 32'd4;
          if (redir) begin
            if (pcsrcD[1]) begin
              w   = mem_word(nxt);
              tgt = {a4[31:28], w[25:0], 2'b00};
            end else begin
              tgt = pcbranchD;
            end
            chk_tgt = 1'b1;
            nxt = tgt;
          end else begin
            nxt = a4;
          end
          exp_q.push_back(nxt);
        end
      end

      @(negedge clk);
      if (!reset) begin
        if (first_req) begin
          n_chk++;
          if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL first_req: imem_req=%b imem_addr=%h, required 1 %h", imem_req, imem_addr, RST_PC);
          end
          first_req = 1'b0;
        end
        if (stallF) begin
          n_chk++;
          if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_under_stallF: imem_req=%b, required 0", imem_req);
          end
        end
        if (redir) begin
          n_chk++;
          if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_in_redirect: imem_req=%b, required 0", imem_req);
          end
        end
        if (imem_req === 1'b1) begin
          n_chk++;
          if (pend) begin
            n_fail++;
            $display("FAIL one_outstanding: new request at %h, required none while %h pending", imem_addr, paddr);
          end
          pend  = 1'b1;
          paddr = imem_addr;
          cnt   = phase1 ? 1 : int'($urandom_range(1, 4));
        end
      end
    end

    n_chk++;
    if (n_deliv < 200) begin
      n_fail++;
      $display("FAIL progress: %0d instructions delivered, required at least 200", n_deliv);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined MIPS core. It sits directly upstream of decode and the main controller. It owns the PC and issues one-at-a-time requests to a variable-latency instruction memory. It delivers fetched instructions, or bubbles, into IF/ID, and applies the decode-stage redirect (`pcsrcD`/`orpcsrcD`) that the controller produces.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stallF` in 1: hazard unit; blocks issue of a new imem request.
- `stallD` in 1: hazard unit; IF/ID holds and no redirect is taken.
- `pcsrcD` in 2: next-PC select from the controller (00 = PC+4, 01 = branch, 10 = jump; 11 is treated as jump).
- `orpcsrcD` in 1: redirect request from the controller (OR of `pcsrcD` bits).
- `pcbranchD` in 32: branch target computed by the decode datapath.
- `imem_req` out 1: one-cycle request pulse.
- `imem_addr` out 32: request address, equal to `pcF`.
- `imem_valid` in 1: response strobe, at least 1 cycle after the request.
- `imem_rdata` in 32: instruction word, valid with `imem_valid`.
- `pcF` out 32: current fetch PC.
- `instrD` out 32: IF/ID instruction.
- `pcplus4D` out 32: IF/ID PC+4.
- `validD` out 1: IF/ID holds a real instruction (0 = bubble).

## Operation
- FSM states: FETCH, WAIT and HOLD. The block also keeps a `drop` flag, a hold buffer (`hbuf_instr`, `hbuf_pc`) and a `redirect` signal.
- `redirect` = `orpcsrcD & validD & !stallD`.
- Redirect target: `pcsrcD[1]` selects {`pcplus4D[31:28]`, `instrD[25:0]`, 2'b00}; otherwise `pcbranchD`.
- FETCH:
  - If `!stallF` and no redirect: `imem_req`=1, `imem_addr`=`pcF`, next state WAIT.
  - If `stallF`: no request, stay in FETCH.
- WAIT:
  - On `imem_valid`, if `drop` is set: discard the response, clear `drop`, go to FETCH.
  - On `imem_valid`, if `drop` is clear and `!stallD`: load IF/ID with {`imem_rdata`, `pcF`+4, valid=1}, set `pcF` to `pcF`+4, go to FETCH.
  - On `imem_valid`, if `drop` is clear and `stallD`: write the hold buffer, set `pcF` to `pcF`+4, go to HOLD.
- HOLD: on the first cycle with `!stallD`, load IF/ID from the hold buffer and go to FETCH.
- Redirect, which takes priority over all of the above:
  - `pcF` is loaded with the target.
  - IF/ID is loaded with a bubble.
  - The hold buffer is discarded.
  - If a request is outstanding (WAIT without `imem_valid` this cycle), set `drop` and stay in WAIT.
  - Otherwise go to FETCH. A FETCH-state request is suppressed in a redirect cycle.
- Bubble insertion: whenever `!stallD` and no instruction is delivered, IF/ID is loaded with `instrD`=0 (sll nop), `pcplus4D`=0 and `validD`=0.
- `stallD`=1: the IF/ID register holds its value unchanged.
- At most one imem request is outstanding at any time.
- Arithmetic: PC+4 is a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No misalignment check is performed.

## Timing
- Reset values:
  - `pcF` = `RESET_PC`, state = FETCH, `drop` = 0.
  - `instrD` = 0, `pcplus4D` = 0, `validD` = 0.
  - `imem_req` = 0 while `reset` is high.
  - The first request is issued in the first cycle after reset deasserts.
- Reset mid-WAIT abandons the outstanding request. The instruction memory shares this reset and does not return a response afterwards.
- Latency:
  - Request in cycle t, `imem_valid` in cycle t+L (L ≥ 1).
  - The instruction is visible in `instrD` at t+L+1.
  - Peak throughput is one instruction per L+1 cycles.
- A redirect taken in cycle t makes `pcF` equal the target at t+1, and the target request is issued no earlier than t+1.
- `imem_req` is a Moore-style output: a function of state, `stallF`, `redirect` and `reset`. It never depends on `imem_valid`.

## Structure
- Shared package `mips_pkg`:
  - `pcsrc` encodings: `PCSRC_PLUS4` = 2'b00, `PCSRC_BRANCH` = 2'b01, `PCSRC_JUMP` = 2'b10.
  - `NOP_INSTR` = 32'h0.
  - The `fetch_state_t` enum.
- One sub-module, `ifid_reg`: a 65-bit register with synchronous reset, enable and clear, holding {valid, instr, pcplus4}.
- The FSM, PC register and hold buffer live in `fetch_stage`.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000 and memory latency L=1 → first `imem_addr`=32'h0040_0000. `instrD` values appear every 2 cycles with `pcplus4D` = 0x00400004, 0x00400008, ….
- Taken branch: `pcsrcD`=01 and `pcbranchD`=32'h0040_0100 while `validD`=1 → `pcF`=32'h0040_0100 next cycle and `validD`=0 (bubble).
- Jump: `instrD`=32'h0810_0040 (j) with `pcplus4D`=32'h0040_0008 → `pcF`=32'h0040_0100.
- Redirect during WAIT with L=3 → the stale response is dropped, never reaches `instrD`, and the next request goes to the target.
- `stallD` held for 4 cycles while a response arrives → `instrD` stays constant, and the buffered word appears in the cycle after `stallD` falls with `pcF` advanced by exactly 4.
- `stallF`=1 in FETCH → no `imem_req`; `pcF` and `instrD` are unchanged and bubbles are inserted.
